// File: rtl/frame_capture_pkg.sv
// Shared state encoding and default sizes for the frame capture sink.
package frame_capture_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t CAPT  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t HOLD  = 2'd3;

  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 5;
  localparam int DEF_REQ_LOW = 4;

endpackage

// File: rtl/fc_ram.sv
// Frame buffer: one synchronous write port, combinational read port.
module fc_ram
  import frame_capture_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Contents are not reset; only the written bitmap in the parent says what is valid.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/frame_capture.sv
// Captures one write burst into a buffer, drains it in address order on a
// valid/ready stream, and gates the upstream burst request until the buffer is free.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int REQ_LOW = DEF_REQ_LOW  // must be >= 3 for a 2-flop req synchronizer upstream
) (
  input  logic          clk,
  input  logic          rst,
  output logic          req,
  input  logic          csn,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_hole,
  output logic [AW:0]   frame_len,
  output logic          err
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2(REQ_LOW) + 1;

  state_t          state_r;
  state_t          state_nx;
  logic [DEPTH-1:0] written_r;
  logic [AW-1:0]   hi_r;
  logic [AW:0]     rd_r;
  logic [CW-1:0]   hold_cnt_r;
  logic [DW-1:0]   rdata_s;
  logic            any_written_s;
  logic            acc_s;
  logic            hold_done_s;
  logic            load_s;
  logic            req_nx_s;

  assign any_written_s = |written_r;
  assign acc_s         = ((state_r == IDLE) || (state_r == CAPT)) && !csn && we;
  assign hold_done_s   = (hold_cnt_r == CW'(REQ_LOW - 1));

  fc_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .wen   (acc_s),
    .waddr (addr),
    .wdata (wdata),
    .raddr (rd_r[AW-1:0]),
    .rdata (rdata_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // An empty frame skips DRAIN entirely so req stays low for exactly REQ_LOW cycles.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (!csn) state_nx = CAPT;
        else      state_nx = IDLE;
      end
      CAPT: begin
        if (csn) begin
          if (any_written_s) state_nx = DRAIN;
          else               state_nx = HOLD;
        end else begin
          state_nx = CAPT;
        end
      end
      DRAIN: begin
        if (!any_written_s || (out_valid && out_ready && out_last)) state_nx = HOLD;
        else                                                        state_nx = DRAIN;
      end
      HOLD: begin
        if (hold_done_s) state_nx = IDLE;
        else             state_nx = HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_nx_s = 1'b0;
    load_s   = 1'b0;
    if ((state_nx == IDLE) || (state_nx == CAPT)) req_nx_s = 1'b1;
    else                                          req_nx_s = 1'b0;
    if ((state_r == DRAIN) && any_written_s && (rd_r <= {1'b0, hi_r}) &&
        (!out_valid || out_ready)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req        <= 1'b0;
      written_r  <= '0;
      hi_r       <= '0;
      rd_r       <= '0;
      hold_cnt_r <= '0;
      frame_len  <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_hole   <= 1'b0;
    end else begin
      req <= req_nx_s;

      if ((state_r == HOLD) && hold_done_s) begin
        written_r <= '0;
        hi_r      <= '0;
        rd_r      <= '0;
      end else begin
        if (acc_s) begin
          written_r[addr] <= 1'b1;
          if (addr > hi_r) hi_r <= addr;
        end
        if (load_s) rd_r <= rd_r + (AW+1)'(1);
      end

      if (state_r == HOLD) hold_cnt_r <= hold_cnt_r + CW'(1);
      else                 hold_cnt_r <= '0;

      if ((state_r == CAPT) && csn) begin
        frame_len <= any_written_s ? ({1'b0, hi_r} + (AW+1)'(1)) : '0;
      end

      if ((we && csn) || (!csn && ((state_r == DRAIN) || (state_r == HOLD)))) begin
        err <= 1'b1;
      end

      // Output register only advances when empty or the current beat is taken.
      if (load_s) begin
        out_valid <= 1'b1;
        out_data  <= rdata_s;
        out_hole  <= !written_r[rd_r[AW-1:0]];
        out_last  <= (rd_r == {1'b0, hi_r});
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench: drives bursts like the upstream FSM and checks the drained
// stream against a per-frame address-ordered model of what was written.
module tb_frame_capture;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst, req, csn, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, out_data;
  logic          out_valid, out_ready, out_last, out_hole, err;
  logic [AW:0]   frame_len;

  always #5 clk = ~clk;

  frame_capture #(.DW(DW), .AW(AW), .REQ_LOW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .csn(csn), .we(we), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_hole(out_hole), .frame_len(frame_len), .err(err)
  );

  typedef struct { logic [DW-1:0] data; logic hole; logic last; } beat_t;

  int            n_checks = 0;
  int            n_errors = 0;
  beat_t         exp_q[$];
  beat_t         b;
  logic [DW-1:0] m_data [DEPTH];
  logic          m_wr   [DEPTH];
  int            m_hi = -1;
  int            frame_seq = 0, seen_seq = 0, frame_beats = 0, frame_holes = 0;
  logic [DW-1:0] first_data = '0, last_data = '0;
  logic          exp_err = 1'b0, viol = 1'b0, run_checks = 1'b0, prev_stall = 1'b0;
  beat_t         prev_beat;
  int            rdy_mode = 0;
  logic [3:0]    rdy_pat = 4'b1001;
  logic [AW-1:0] f_addr[$];
  logic [DW-1:0] f_data[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Ready pattern generator: constant, 1,0,0,1 repeating, or random.
  initial begin
    int pi;
    pi = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = rdy_pat[pi]; pi = (pi + 1) % 4; end
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Compare process: every cycle checks err, stall stability and each accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (run_checks) begin
        check("err", 32'(err), 32'(exp_err));
        if (rst) begin
          exp_q.delete();
          exp_err    = 1'b0;
          prev_stall = 1'b0;
        end else begin
          if (frame_seq != seen_seq) begin
            seen_seq    = frame_seq;
            frame_beats = 0;
            frame_holes = 0;
            for (int a = 0; a <= m_hi; a++) begin
              b.data = m_data[a];
              b.hole = !m_wr[a];
              b.last = (a == m_hi);
              exp_q.push_back(b);
            end
          end
          if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(out_data),  32'(prev_beat.data));
            check("stall_last",  32'(out_last),  32'(prev_beat.last));
            check("stall_hole",  32'(out_hole),  32'(prev_beat.hole));
          end
          if (out_valid) check("req_low_while_valid", 32'(req), 32'd0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL extra_beat: got beat data %0h, expected no beat at %0t", out_data, $time);
            end else begin
              b = exp_q.pop_front();
              check("beat_hole", 32'(out_hole), 32'(b.hole));
              check("beat_last", 32'(out_last), 32'(b.last));
              if (!b.hole) check("beat_data", 32'(out_data), 32'(b.data));
            end
            frame_beats++;
            if (out_hole) frame_holes++;
            if (frame_beats == 1) first_data = out_data;
            if (out_last) last_data = out_data;
          end
          prev_stall     = out_valid && !out_ready;
          prev_beat.data = out_data;
          prev_beat.last = out_last;
          prev_beat.hole = out_hole;
          if ((we && csn) || viol) exp_err = 1'b1;
        end
      end
    end
  end

  task automatic wait_req();
    int k;
    k = 0;
    @(negedge clk);
    while (!req && k < 200) begin @(negedge clk); k++; end
    check("req_wait", 32'(req), 32'd1);
  endtask

  task automatic do_frame(input int pre, input int gap_pct);
    wait_req();
    for (int a = 0; a < DEPTH; a++) begin m_wr[a] = 1'b0; m_data[a] = '0; end
    m_hi = -1;
    @(posedge clk); #1;
    for (int i = 0; i < pre; i++) begin csn = 1'b0; we = 1'b0; @(posedge clk); #1; end
    for (int i = 0; i < f_addr.size(); i++) begin
      if (32'($urandom_range(99)) < 32'(gap_pct)) begin
        csn = 1'b0; we = 1'b0; @(posedge clk); #1;
      end
      csn = 1'b0; we = 1'b1; addr = f_addr[i]; wdata = f_data[i];
      m_data[f_addr[i]] = f_data[i];
      m_wr[f_addr[i]]   = 1'b1;
      if (int'(f_addr[i]) > m_hi) m_hi = int'(f_addr[i]);
      @(posedge clk); #1;
    end
    csn = 1'b1; we = 1'b0;
    frame_seq++;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !req) && k < 600) begin @(negedge clk); k++; end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("req_back", 32'(req), 32'd1);
  endtask

  task automatic finish_frame(input int exp_len);
    @(negedge clk); @(negedge clk);
    check("req_fall", 32'(req), 32'd0);
    check("frame_len", 32'(frame_len), 32'(exp_len));
    if (exp_len > 0) begin
      @(negedge clk);
      check("first_beat_latency", 32'(out_valid), 32'd1);
    end
    wait_drain();
  endtask

  task automatic load_seq20();
    f_addr.delete(); f_data.delete();
    for (int a = 0; a < 20; a++) begin
      f_addr.push_back(AW'(a));
      f_data.push_back(DW'(a) ^ 8'hA5);
    end
  endtask

  initial begin
    int k, cnt, n;
    rst = 1'b1; csn = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_hole", 32'(out_hole), 32'd0);
    rst = 1'b0;
    run_checks = 1'b1;

    // Sequential 20-word burst, constant ready.
    load_seq20(); rdy_mode = 0;
    do_frame(0, 0); finish_frame(20);
    check("t1_beats", 32'(frame_beats), 32'd20);
    check("t1_first", 32'(first_data), 32'hA5);
    check("t1_last", 32'(last_data), 32'hB6);
    check("t1_holes", 32'(frame_holes), 32'd0);
    check("t1_len", 32'(frame_len), 32'd20);

    // Same burst, ready toggling 1,0,0,1.
    rdy_mode = 1;
    do_frame(0, 0); finish_frame(20);
    check("t2_beats", 32'(frame_beats), 32'd20);

    // Sparse frame: only addresses 2 and 5.
    f_addr.delete(); f_data.delete();
    f_addr.push_back(5'd2); f_data.push_back(8'h3C);
    f_addr.push_back(5'd5); f_data.push_back(8'hC3);
    rdy_mode = 0;
    do_frame(0, 0); finish_frame(6);
    check("t3_beats", 32'(frame_beats), 32'd6);
    check("t3_holes", 32'(frame_holes), 32'd4);
    check("t3_last", 32'(last_data), 32'hC3);

    // Empty frame: csn low 3 cycles, no writes.
    f_addr.delete(); f_data.delete();
    do_frame(3, 0);
    @(negedge clk);
    cnt = 0;
    @(negedge clk);
    while (!req && cnt < 50) begin cnt++; @(negedge clk); end
    check("t4_req_low_cycles", 32'(cnt), 32'd4);
    check("t4_len", 32'(frame_len), 32'd0);
    check("t4_beats", 32'(frame_beats), 32'd0);

    // Protocol errors: we while deselected, then csn low during drain.
    @(posedge clk); #1; we = 1'b1;
    @(posedge clk); #1; we = 1'b0;
    load_seq20();
    do_frame(0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1; csn = 1'b0; viol = 1'b1;
    @(posedge clk); #1; csn = 1'b1; viol = 1'b0;
    wait_drain();
    check("t5_err", 32'(err), 32'd1);
    check("t5_beats", 32'(frame_beats), 32'd20);

    // Reset in the middle of a drain, then a clean frame.
    do_frame(0, 0);
    @(negedge clk); @(negedge clk);
    k = 0;
    while (frame_beats < 7 && k < 100) begin @(negedge clk); k++; end
    check("t6_reached_beat7", 32'(frame_beats >= 7), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t6_valid_after_rst", 32'(out_valid), 32'd0);
    check("t6_req_after_rst", 32'(req), 32'd0);
    do_frame(0, 0); finish_frame(20);
    check("t6_beats", 32'(frame_beats), 32'd20);
    check("t6_err_clear", 32'(err), 32'd0);

    // Random bursts with duplicates, gaps and random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      f_addr.delete(); f_data.delete();
      n = int'($urandom_range(24, 1));
      for (int i = 0; i < n; i++) begin
        f_addr.push_back(AW'($urandom_range(DEPTH - 1)));
        f_data.push_back(DW'($urandom));
      end
      do_frame(int'($urandom_range(2)), 25);
      finish_frame(m_hi + 1);
    end

    // Full buffer written top-down: frame_len reaches DEPTH without wrapping.
    f_addr.delete(); f_data.delete();
    for (int a = DEPTH - 1; a >= 0; a--) begin
      f_addr.push_back(AW'(a));
      f_data.push_back(DW'($urandom));
    end
    do_frame(0, 10); finish_frame(DEPTH);
    check("full_len", 32'(frame_len), 32'd32);
    check("full_beats", 32'(frame_beats), 32'd32);
    check("full_holes", 32'(frame_holes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
